// File: rtl/cache_ctrl.sv
// rtl/cache_ctrl.sv - direct-mapped, write-through / no-write-allocate cache controller
// Owns the data array. Tag/valid live in external RAMs that read on negedge.
module cache_ctrl #(
    parameter int memory_bits = 5,
    parameter int cache_size  = 8,
    parameter int index       = 3,
    parameter int data_width  = 8,
    parameter int cnt_width   = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         cpu_req,
    input  logic                         cpu_we,
    input  logic [memory_bits-1:0]       cpu_addr,
    input  logic [data_width-1:0]        cpu_wdata,
    output logic [data_width-1:0]        cpu_rdata,
    output logic                         cpu_ready,
    output logic [index-1:0]             cache_index,
    output logic [memory_bits-index-1:0] tag_in,
    output logic                         tag_we,
    input  logic [memory_bits-index-1:0] tag_out,
    input  logic                         valid_out,
    output logic                         mem_req,
    output logic                         mem_we,
    output logic [memory_bits-1:0]       mem_addr,
    output logic [data_width-1:0]        mem_wdata,
    input  logic [data_width-1:0]        mem_rdata,
    input  logic                         mem_ack,
    output logic [cnt_width-1:0]         hit_count,
    output logic [cnt_width-1:0]         miss_count
);

    typedef enum logic [2:0] {IDLE, LOOKUP, RD_MISS, FILL, WR_MEM, RESP} state_t;

    state_t                  state, state_nx;
    logic [memory_bits-1:0]  req_addr;
    logic                    req_we;
    logic [data_width-1:0]   req_wdata;
    logic [data_width-1:0]   rdata_q;
    logic [data_width-1:0]   data_mem [cache_size];
    logic                    hit;

    // All RAM-facing address outputs come from the latched request so they stay stable until IDLE.
    assign cache_index = req_addr[index-1:0];
    assign tag_in      = req_addr[memory_bits-1:index];
    assign mem_addr    = req_addr;
    assign mem_wdata   = req_wdata;
    assign cpu_rdata   = rdata_q;
    assign hit         = valid_out && (tag_out == req_addr[memory_bits-1:index]);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (cpu_req) state_nx = LOOKUP;
            LOOKUP:  begin
                if (req_we)   state_nx = WR_MEM;
                else if (hit) state_nx = RESP;
                else          state_nx = RD_MISS;
            end
            RD_MISS: if (mem_ack) state_nx = FILL;
            FILL:    state_nx = RESP;
            WR_MEM:  if (mem_ack) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        cpu_ready = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        tag_we    = 1'b0;
        case (state)
            RD_MISS: mem_req = 1'b1;
            WR_MEM:  begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
            end
            FILL:    tag_we = 1'b1;
            RESP:    cpu_ready = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            req_addr   <= '0;
            req_we     <= 1'b0;
            req_wdata  <= '0;
            rdata_q    <= '0;
            hit_count  <= '0;
            miss_count <= '0;
            for (int i = 0; i < cache_size; i++) data_mem[i] <= '0;
        end else begin
            case (state)
                IDLE: if (cpu_req) begin
                    req_addr  <= cpu_addr;
                    req_we    <= cpu_we;
                    req_wdata <= cpu_wdata;
                end
                LOOKUP: begin
                    if (hit) begin
                        if (hit_count != '1) hit_count <= hit_count + 1'b1;
                        if (req_we) data_mem[req_addr[index-1:0]] <= req_wdata;
                        else        rdata_q <= data_mem[req_addr[index-1:0]];
                    end else if (miss_count != '1) begin
                        miss_count <= miss_count + 1'b1;
                    end
                end
                RD_MISS: if (mem_ack) begin
                    rdata_q                      <= mem_rdata;
                    data_mem[req_addr[index-1:0]] <= mem_rdata;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_ctrl.sv
// tb/tb_cache_ctrl.sv - directed self-checking bench for cache_ctrl
// Models the negedge-read tag/valid RAM pair and a main memory with programmable ack delay.
module tb_cache_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       cpu_req, cpu_we;
    logic [4:0] cpu_addr;
    logic [7:0] cpu_wdata, cpu_rdata;
    logic       cpu_ready;
    logic [2:0] cache_index;
    logic [1:0] tag_in, tag_out;
    logic       tag_we, valid_out;
    logic       mem_req, mem_we, mem_ack;
    logic [4:0] mem_addr;
    logic [7:0] mem_wdata, mem_rdata;
    logic [15:0] hit_count, miss_count;

    int n_checks = 0;
    int n_pass   = 0;

    logic [1:0] tag_mem   [8];
    logic       valid_mem [8];

    always #5 clk = ~clk;

    cache_ctrl dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .cache_index(cache_index), .tag_in(tag_in), .tag_we(tag_we),
        .tag_out(tag_out), .valid_out(valid_out),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always @(negedge clk) begin
        tag_out   <= tag_mem[cache_index];
        valid_out <= valid_mem[cache_index];
    end

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                valid_mem[i] <= 1'b0;
                tag_mem[i]   <= 2'b00;
            end
        end else if (tag_we) begin
            tag_mem[cache_index]   <= tag_in;
            valid_mem[cache_index] <= 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // One CPU access; returns latency (accept edge to ready edge) and observed side effects.
    task automatic access(input logic we, input logic [4:0] addr, input logic [7:0] wdata,
                          input int n_ack, input logic [7:0] ack_data,
                          output int lat, output logic [7:0] rdata, output int tagwe_n,
                          output logic [2:0] tw_idx, output logic [1:0] tw_tag,
                          output int req_n, output logic saw_mwe, output logic [7:0] saw_mwdata);
        int  cyc;
        bit  done;
        lat = -1; rdata = 8'h00; tagwe_n = 0; tw_idx = 3'd0; tw_tag = 2'd0;
        req_n = 0; saw_mwe = 1'b0; saw_mwdata = 8'h00; cyc = 0; done = 1'b0;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        @(posedge clk);
        @(negedge clk);
        cpu_req = 1'b0; cpu_addr = ~addr; cpu_wdata = ~wdata;
        while (!done && cyc < 40) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            mem_ack = 1'b0;
            if (tag_we) begin
                tagwe_n++;
                tw_idx = cache_index;
                tw_tag = tag_in;
            end
            if (mem_req) begin
                req_n++;
                saw_mwe    = saw_mwe | mem_we;
                saw_mwdata = mem_wdata;
                if (req_n == n_ack) begin
                    mem_ack   = 1'b1;
                    mem_rdata = ack_data;
                end
            end
            if (cpu_ready) begin
                lat   = cyc + 1;
                rdata = cpu_rdata;
                done  = 1'b1;
            end
        end
        mem_ack = 1'b0;
    endtask

    int         lat, tw_n, rq_n, cyc;
    logic [7:0] rd, mwd;
    logic [2:0] tw_i;
    logic [1:0] tw_t;
    logic       mwe, bad;

    initial begin
        reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 5'h00; cpu_wdata = 8'h00;
        mem_ack = 1'b0; mem_rdata = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", {31'd0, cpu_ready}, 32'd0);
        check("rst_memreq", {31'd0, mem_req}, 32'd0);
        check("rst_tagwe", {31'd0, tag_we}, 32'd0);
        check("rst_counts", {hit_count, miss_count}, 32'd0);
        check("rst_rdata_idx", {21'd0, cpu_rdata, cache_index}, 32'd0);
        reset = 1'b0;

        // 1: cold load miss, ack on the 2nd mem_req cycle
        access(1'b0, 5'h0B, 8'h00, 2, 8'hA5, lat, rd, tw_n, tw_i, tw_t, rq_n, mwe, mwd);
        check("t1_lat", lat, 5);
        check("t1_rdata", rd, 8'hA5);
        check("t1_tagwe_n", tw_n, 1);
        check("t1_tagwe_idx_tag", {tw_i, tw_t}, {3'd3, 2'b01});
        check("t1_miss", miss_count, 1);

        // 2: same address hits
        access(1'b0, 5'h0B, 8'h00, 1, 8'hEE, lat, rd, tw_n, tw_i, tw_t, rq_n, mwe, mwd);
        check("t2_lat", lat, 2);
        check("t2_rdata", rd, 8'hA5);
        check("t2_no_memreq", rq_n, 0);
        check("t2_hit", hit_count, 1);

        // 3: conflict on index 3
        access(1'b0, 5'h13, 8'h00, 1, 8'h77, lat, rd, tw_n, tw_i, tw_t, rq_n, mwe, mwd);
        check("t3_lat", lat, 4);
        check("t3_rdata", rd, 8'h77);
        access(1'b0, 5'h0B, 8'h00, 1, 8'hA5, lat, rd, tw_n, tw_i, tw_t, rq_n, mwe, mwd);
        check("t3_evict_memreq", rq_n, 1);
        check("t3_miss", miss_count, 3);

        // 4: bring 0x13 back, then store-hit and load-hit
        access(1'b0, 5'h13, 8'h00, 1, 8'h77, lat, rd, tw_n, tw_i, tw_t, rq_n, mwe, mwd);
        check("t4_reload_miss", miss_count, 4);
        access(1'b1, 5'h13, 8'h3C, 1, 8'h00, lat, rd, tw_n, tw_i, tw_t, rq_n, mwe, mwd);
        check("t4_st_lat", lat, 3);
        check("t4_st_mwe", {31'd0, mwe}, 32'd1);
        check("t4_st_mwdata", mwd, 8'h3C);
        check("t4_st_tagwe", tw_n, 0);
        check("t4_st_rdata_held", rd, 8'h77);
        check("t4_st_hit", hit_count, 2);
        access(1'b0, 5'h13, 8'h00, 1, 8'hEE, lat, rd, tw_n, tw_i, tw_t, rq_n, mwe, mwd);
        check("t4_ld_lat", lat, 2);
        check("t4_ld_rdata", rd, 8'h3C);

        // 5: store miss does not allocate
        access(1'b1, 5'h04, 8'h99, 3, 8'h00, lat, rd, tw_n, tw_i, tw_t, rq_n, mwe, mwd);
        check("t5_st_lat", lat, 5);
        check("t5_st_tagwe", tw_n, 0);
        check("t5_st_mwdata", mwd, 8'h99);
        access(1'b0, 5'h04, 8'h00, 1, 8'h5A, lat, rd, tw_n, tw_i, tw_t, rq_n, mwe, mwd);
        check("t5_ld_memreq", rq_n, 1);
        check("t5_ld_rdata", rd, 8'h5A);
        check("t5_counts", {hit_count, miss_count}, {16'd3, 16'd6});

        // Top index line behaves like the others
        access(1'b0, 5'h1F, 8'h00, 1, 8'hC3, lat, rd, tw_n, tw_i, tw_t, rq_n, mwe, mwd);
        check("idx7_fill", {tw_i, tw_t}, {3'd7, 2'b11});
        access(1'b0, 5'h1F, 8'h00, 1, 8'hEE, lat, rd, tw_n, tw_i, tw_t, rq_n, mwe, mwd);
        check("idx7_hit", {lat[7:0], rd}, {8'd2, 8'hC3});

        // 6: reset during RD_MISS
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'h02;
        @(posedge clk);
        @(negedge clk);
        cpu_req = 1'b0;
        cyc = 0;
        while (!mem_req && cyc < 10) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        check("t6_memreq_up", {31'd0, mem_req}, 32'd1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("t6_memreq_dropped", {31'd0, mem_req}, 32'd0);
        check("t6_no_ready", {31'd0, cpu_ready}, 32'd0);
        check("t6_counts", {hit_count, miss_count}, 32'd0);
        reset = 1'b0;
        mem_ack = 1'b1; mem_rdata = 8'hFF;
        bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            @(negedge clk);
            mem_ack = 1'b0;
            if (cpu_ready || mem_req || tag_we) bad = 1'b1;
        end
        check("t6_stray_ack_ignored", {31'd0, bad}, 32'd0);
        check("t6_rdata_cleared", cpu_rdata, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
